inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, address of the first fetch after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  output  1  memory fetch request valid.
REQ-005 Port: req_ready  input  1  memory accepts request.
REQ-006 Port: req_addr  output  32  fetch address, always equal to internal pc.
REQ-007 Port: resp_valid  input  1  memory returns instruction word (single-cycle pulse).
REQ-008 Port: resp_data  input  32  returned instruction word.
REQ-009 Port: inst_valid  output  1  instruction available to decode stage.
REQ-010 Port: inst_ready  input  1  decode stage consumes instruction.
REQ-011 Port: inst  output  32  instruction word to decode stage.
REQ-012 Port: inst_pc  output  32  address of inst.
REQ-013 Port: redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-014 Port: redirect_pc  input  32  new fetch address.
REQ-015 Port: halted  output  1  fetch stopped on halt instruction (macro-dependent, see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, OUT, HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset deassertion and then go to REQ.
REQ-018 In REQ, req_valid SHALL be 1; on req_valid&&req_ready the FSM SHALL go to WAIT.
REQ-019 In WAIT, on resp_valid the FSM SHALL latch resp_data into inst, pc into inst_pc, and go to OUT.
REQ-020 In OUT, inst_valid SHALL be 1 and inst/inst_pc SHALL hold stable until inst_valid&&inst_ready.
REQ-021 On inst_valid&&inst_ready without redirect, pc SHALL become pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and the FSM SHALL go to REQ.
REQ-022 Fetch-to-inst_valid latency with req_ready=1 and 1-cycle memory SHALL be 2 cycles after request acceptance; back-to-back throughput SHALL be one instruction per 3 cycles minimum.
REQ-023 resp_valid outside WAIT SHALL be ignored.
REQ-024 redirect_valid in any state except HALT SHALL load pc<=redirect_pc; redirect SHALL take priority over pc+4.
REQ-025 Redirect in OUT SHALL drop the held instruction (inst_valid 0 next cycle) and go to REQ, even if inst_ready is simultaneously 1.
REQ-026 Redirect in REQ without req_ready SHALL go to REQ with the new address; with req_ready the accepted request SHALL be marked killed and the FSM SHALL go to WAIT.
REQ-027 Redirect in WAIT SHALL set a kill flag; the next response SHALL be discarded, the FSM SHALL go to REQ, and the kill flag SHALL clear.
REQ-028 Redirect coinciding with resp_valid in WAIT SHALL discard that response and go to REQ.
REQ-029 At most one request SHALL be outstanding at any time.

Reset
REQ-030 rst SHALL force state IDLE, pc=RESET_PC, kill=0, req_valid=0, inst_valid=0, inst=0, inst_pc=0, halted=0 at the next rising edge.
REQ-031 rst asserted mid-transaction SHALL abandon any outstanding request; a response arriving after reset SHALL be ignored by IDLE.

Configuration
REQ-032 Macro IFU_HALT_DETECT_EN defined: an accepted (non-killed) resp_data==32'h0 SHALL still be presented in OUT; after its inst handshake the FSM SHALL enter HALT, deassert req_valid, set halted=1, ignore redirect, and remain until rst.
REQ-033 Macro IFU_HALT_DETECT_EN undefined: HALT SHALL be unreachable, halted SHALL be tied 0, and all-zero words SHALL be treated as ordinary instructions.

Verification
REQ-034 Reset, req_ready=1, 1-cycle memory returning 32'h00000013 -> req_addr 8000_0000 then 8000_0004; inst_valid with inst_pc 8000_0000, then 8000_0004.
REQ-035 inst_ready held 0 for 5 cycles in OUT -> inst/inst_pc stable, no new req_valid; consumed on cycle 6, next req_addr +4.
REQ-036 redirect_valid with redirect_pc=8000_0100 during WAIT -> the arriving response is discarded, next req_addr 8000_0100, first inst_pc 8000_0100.
REQ-037 redirect in OUT simultaneous with inst_ready=1 -> no pc+4, next req_addr = redirect_pc.
REQ-038 pc=FFFF_FFFC consumed -> next req_addr 0000_0000.
REQ-039 With IFU_HALT_DETECT_EN, resp_data=0 consumed -> halted=1, req_valid stays 0 for 20 cycles despite redirect; rst clears halted.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit signal bundle: memory request/response, decode handoff and redirect.
// master = fetch unit, slave = memory/decode/branch environment.
interface inst_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, halted,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, halted,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch FSM: IDLE -> REQ -> WAIT -> OUT, with redirect/kill.
// Optional halt on all-zero instruction word when IFU_HALT_DETECT_EN is defined.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    HALT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          // A request accepted in the redirect cycle fetches the stale address.
          if (bus.req_ready) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end else if (bus.req_ready) begin
          state_d = WAIT;
          kill_d  = 1'b0;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.resp_valid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (bus.resp_valid) begin
          if (kill_q) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            inst_d    = bus.resp_data;
            inst_pc_d = pc_q;
            state_d   = OUT;
          end
        end
      end
      OUT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = REQ;
        end else if (bus.inst_ready) begin
`ifdef IFU_HALT_DETECT_EN
          if (inst_q == 32'h0) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
`else
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
`endif
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_valid  = (state_q == REQ);
  assign bus.req_addr   = pc_q;
  assign bus.inst_valid = (state_q == OUT);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

`ifdef IFU_HALT_DETECT_EN
  assign bus.halted = (state_q == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, hand-written corner sequences,
// then randomized traffic against a transaction-level fetch model.
module tb_inst_fetch;
  localparam logic [31:0] R = 32'h8000_0000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rr;
    logic        rsv;
    logic [31:0] rsd;
    logic        ir;
    logic        redv;
    logic [31:0] redpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic r, rr, rsv, input logic [31:0] rsd,
                              input logic ir, redv, input logic [31:0] redpc,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst, e_ipc);
    vec_t v;
    v = '{r, rr, rsv, rsd, ir, redv, redpc, e_rv, e_addr, e_iv, e_inst, e_ipc};
    return v;
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a ^ 32'h5A3C_96E0) | 32'h1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, rr, rsv, input logic [31:0] rsd,
                       input logic ir, redv, input logic [31:0] redpc);
    @(negedge clk);
    rst                = r;
    bus.req_ready      = rr;
    bus.resp_valid     = rsv;
    bus.resp_data      = rsd;
    bus.inst_ready     = ir;
    bus.redirect_valid = redv;
    bus.redirect_pc    = redpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic rv, input logic [31:0] addr,
                            input logic iv, input logic [31:0] ins, ipc, input logic hlt);
    chk({tag, ".req_valid"},  {31'b0, bus.req_valid},  {31'b0, rv});
    chk({tag, ".req_addr"},   bus.req_addr,            addr);
    chk({tag, ".inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, iv});
    chk({tag, ".inst"},       bus.inst,                ins);
    chk({tag, ".inst_pc"},    bus.inst_pc,             ipc);
    chk({tag, ".halted"},     {31'b0, bus.halted},     {31'b0, hlt});
  endtask

  initial begin
    logic [31:0] exp_pc, out_addr, redpc, rsd, rnd;
    logic        outst, out_kill, exp_held, rr, ir, redv, rsv, resp_now, acc;
    int          cnt;

    rst = 1'b1;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = '0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

    // Directed cycle table: inputs applied for one edge, outputs after that edge.
    tbl[0]  = mk(1,0,0,0,            0,0,0,          0,R,        0,0,0);
    tbl[1]  = mk(1,0,0,0,            0,0,0,          0,R,        0,0,0);
    tbl[2]  = mk(0,0,0,0,            0,0,0,          1,R,        0,0,0);
    tbl[3]  = mk(0,1,0,0,            0,0,0,          0,R,        0,0,0);
    tbl[4]  = mk(0,1,1,32'h13,       0,0,0,          0,R,        1,32'h13,R);
    tbl[5]  = mk(0,0,0,0,            1,0,0,          1,R+4,      0,32'h13,R);
    tbl[6]  = mk(0,1,0,0,            0,0,0,          0,R+4,      0,32'h13,R);
    tbl[7]  = mk(0,0,1,32'h13,       0,0,0,          0,R+4,      1,32'h13,R+4);
    tbl[8]  = mk(0,0,0,0,            1,1,R+32'h200,  1,R+32'h200,0,32'h13,R+4);
    tbl[9]  = mk(0,1,0,0,            0,0,0,          0,R+32'h200,0,32'h13,R+4);
    tbl[10] = mk(0,0,0,0,            0,1,R+32'h100,  0,R+32'h100,0,32'h13,R+4);
    tbl[11] = mk(0,0,1,32'hDEADBEEF, 0,0,0,          1,R+32'h100,0,32'h13,R+4);
    tbl[12] = mk(0,1,0,0,            0,0,0,          0,R+32'h100,0,32'h13,R+4);
    tbl[13] = mk(0,0,1,32'h93,       0,0,0,          0,R+32'h100,1,32'h93,R+32'h100);
    tbl[14] = mk(0,0,0,0,            1,0,0,          1,R+32'h104,0,32'h93,R+32'h100);
    tbl[15] = mk(0,1,0,0,            0,0,0,          0,R+32'h104,0,32'h93,R+32'h100);
    tbl[16] = mk(0,0,1,32'h11111111, 0,1,R+32'h300,  1,R+32'h300,0,32'h93,R+32'h100);
    tbl[17] = mk(0,1,0,0,            0,1,R+32'h400,  0,R+32'h400,0,32'h93,R+32'h100);
    tbl[18] = mk(0,0,1,32'h22222222, 0,0,0,          1,R+32'h400,0,32'h93,R+32'h100);
    tbl[19] = mk(0,0,0,0,            0,1,R+32'h500,  1,R+32'h500,0,32'h93,R+32'h100);
    tbl[20] = mk(0,0,1,32'h33333333, 0,0,0,          1,R+32'h500,0,32'h93,R+32'h100);
    tbl[21] = mk(0,1,0,0,            0,0,0,          0,R+32'h500,0,32'h93,R+32'h100);
    tbl[22] = mk(0,0,1,32'h44444444, 0,0,0,          0,R+32'h500,1,32'h44444444,R+32'h500);
    tbl[23] = mk(0,0,1,32'h55555555, 0,0,0,          0,R+32'h500,1,32'h44444444,R+32'h500);
    tbl[24] = mk(0,0,0,0,            1,0,0,          1,R+32'h504,0,32'h44444444,R+32'h500);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].rr, tbl[i].rsv, tbl[i].rsd, tbl[i].ir, tbl[i].redv, tbl[i].redpc);
      expect_out($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
                 tbl[i].e_inst, tbl[i].e_ipc, 1'b0);
    end

    // Decode stall: held word stays stable with no new request.
    drive(0,1,0,0, 0,0,0);
    drive(0,0,1,32'h66666666, 0,0,0);
    expect_out("stall_out", 0, R+32'h504, 1, 32'h66666666, R+32'h504, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0,1,0,0, 0,0,0);
      expect_out($sformatf("stall%0d", k), 0, R+32'h504, 1, 32'h66666666, R+32'h504, 0);
    end
    drive(0,1,0,0, 1,0,0);
    expect_out("stall_done", 1, R+32'h508, 0, 32'h66666666, R+32'h504, 0);

    // Address wrap from the top of the address space.
    drive(0,0,0,0, 0,1,32'hFFFF_FFFC);
    expect_out("wrap_redir", 1, 32'hFFFF_FFFC, 0, 32'h66666666, R+32'h504, 0);
    drive(0,1,0,0, 0,0,0);
    drive(0,0,1,32'h77777777, 0,0,0);
    expect_out("wrap_out", 0, 32'hFFFF_FFFC, 1, 32'h77777777, 32'hFFFF_FFFC, 0);
    drive(0,0,0,0, 1,0,0);
    expect_out("wrap_next", 1, 32'h0, 0, 32'h77777777, 32'hFFFF_FFFC, 0);

    // Reset with a request outstanding; the late response lands in IDLE.
    drive(0,1,0,0, 0,0,0);
    drive(1,0,0,0, 0,0,0);
    expect_out("rst_mid", 0, R, 0, 32'h0, 32'h0, 0);
    drive(0,0,1,32'h88888888, 0,0,0);
    expect_out("rst_late_resp", 1, R, 0, 32'h0, 32'h0, 0);
    drive(0,1,0,0, 0,0,0);
    drive(0,0,1,32'h99999999, 0,0,0);
    expect_out("rst_refetch", 0, R, 1, 32'h99999999, R, 0);
    drive(0,0,0,0, 1,0,0);
    expect_out("rst_next", 1, R+4, 0, 32'h99999999, R, 0);

    // All-zero instruction word.
    drive(0,1,0,0, 0,0,0);
    drive(0,0,1,32'h0, 0,0,0);
    expect_out("zero_out", 0, R+4, 1, 32'h0, R+4, 0);
    drive(0,0,0,0, 1,0,0);
`ifdef IFU_HALT_DETECT_EN
    expect_out("halt_enter", 0, R+4, 0, 32'h0, R+4, 1);
    for (int k = 0; k < 20; k++) begin
      rnd = $urandom();
      drive(0,1,k[0],rnd, 1,1,rnd & 32'hFFFF_FFFC);
      expect_out($sformatf("halt%0d", k), 0, R+4, 0, 32'h0, R+4, 1);
    end
    drive(1,0,0,0, 0,0,0);
    expect_out("halt_rst", 0, R, 0, 32'h0, 32'h0, 0);
`else
    expect_out("zero_plain", 1, R+8, 0, 32'h0, R+4, 0);
`endif

    // Randomized traffic against a transaction-level model.
    drive(1,0,0,0, 0,0,0);
    exp_pc = R; outst = 0; out_kill = 0; exp_held = 0; out_addr = '0; cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rr   = ($urandom_range(0,3) != 0);
      ir   = ($urandom_range(0,2) != 0);
      redv = ($urandom_range(0,11) == 0);
      rnd  = $urandom();
      redpc = rnd & 32'hFFFF_FFFC;
      rsv = 1'b0; rsd = $urandom();
      if (outst) begin
        if (cnt <= 1) begin rsv = 1'b1; rsd = memw(out_addr); end
        else cnt--;
      end else begin
        rsv = ($urandom_range(0,7) == 0);
      end
      rst = 1'b0;
      bus.req_ready = rr; bus.resp_valid = rsv; bus.resp_data = rsd;
      bus.inst_ready = ir; bus.redirect_valid = redv; bus.redirect_pc = redpc;

      chk("rnd.inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_held});
      chk("rnd.halted", {31'b0, bus.halted}, 32'h0);
      if (bus.req_valid) begin
        chk("rnd.single_outstanding", {31'b0, outst}, 32'h0);
        chk("rnd.req_addr", bus.req_addr, exp_pc);
      end
      if (bus.inst_valid && exp_held) begin
        chk("rnd.inst", bus.inst, memw(exp_pc));
        chk("rnd.inst_pc", bus.inst_pc, exp_pc);
      end

      resp_now = outst && rsv;
      acc      = bus.req_valid && rr;
      if (resp_now) begin
        if (!out_kill && !redv) exp_held = 1'b1;
        outst = 1'b0; out_kill = 1'b0;
      end
      if (redv) begin
        exp_held = 1'b0;
        if (outst) out_kill = 1'b1;
        if (acc) begin outst = 1'b1; out_kill = 1'b1; out_addr = exp_pc; cnt = $urandom_range(1,4); end
        exp_pc = redpc;
      end else begin
        if (bus.inst_valid && ir) begin exp_held = 1'b0; exp_pc = exp_pc + 32'd4; end
        if (acc) begin outst = 1'b1; out_kill = 1'b0; out_addr = exp_pc; cnt = $urandom_range(1,4); end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
